// File: rtl/s9234_cone_eval_ctrl.sv
// ---------------------------------------------------------------------------
// s9234_cone_eval_ctrl
//
// Purpose:
//   Sequences evaluation of the combinationally-extracted s9234 partial-output
//   cone (output n1146). Vectors arrive on a valid/ready stream. Each vector is
//   registered onto the cone inputs and held for SETTLE_CYCLES cycles, then
//   n1146 is sampled. The responses are compacted into a 16-bit MISR signature
//   and a saturating ones count. This block stands in for the cut flip-flops so
//   the cone can be checked against a golden signature.
//
// Ports:
//   CK          in   1   clock, all state updates on the rising edge
//   RN          in   1   asynchronous active-low reset
//   start       in   1   begin a run (only looked at in IDLE or DONE)
//   num_vecs    in   16  vectors in the run, latched when start is accepted
//   vec_valid   in   1   vector source has data
//   vec_ready   out  1   controller can take a vector (high only in LOAD)
//   vec_data    in   18  {g170,...,g94}: bit 0 = g94 ... bit 17 = g170
//   cone_in     out  18  registered drive to the cone, same order as vec_data
//   cone_out    in   1   n1146 from the cone
//   busy        out  1   run in progress (cycle after start .. DONE entered)
//   done        out  1   level, high in DONE until the next accepted start
//   signature   out  16  MISR state
//   ones_count  out  16  captures where cone_out was 1, saturating
//   dbg_state   out  3   current FSM state: 0 IDLE, 1 LOAD, 2 APPLY,
//                        3 CAPTURE, 4 DONE
//
// Handshake: a vector transfers on a rising CK edge where vec_valid and
// vec_ready are both high. vec_ready depends only on state, never on
// vec_valid; the source must hold vec_data stable while vec_valid is high and
// no transfer has occurred.
// ---------------------------------------------------------------------------
module s9234_cone_eval_ctrl #(
    parameter int SETTLE_CYCLES = 2,   // legal range 1..15
    parameter int SIG_W         = 16   // fixed at 16 in this revision
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic [15:0]      num_vecs,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [17:0]      vec_data,
    output logic [17:0]      cone_in,
    input  logic             cone_out,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [SIG_W-1:0] ones_count,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_APPLY   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [SIG_W-1:0] MISR_POLY   = SIG_W'(16'h1021);
    localparam logic [SIG_W-1:0] SIG_SEED    = {SIG_W{1'b1}};
    localparam logic [SIG_W-1:0] ONES_MAX    = {SIG_W{1'b1}};

    logic [2:0]       r_state;
    logic [17:0]      r_cone_in;
    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] r_ones;
    logic [15:0]      r_vec_cnt;
    logic [15:0]      r_num_vecs;
    logic [3:0]       r_settle;
    logic             r_busy;
    logic             r_done;

    logic             w_vec_ready;
    logic             w_accept;
    logic [SIG_W-1:0] w_misr_next;
    logic [15:0]      w_vec_cnt_next;

    assign w_vec_ready    = (r_state == ST_LOAD);
    assign w_accept       = w_vec_ready && vec_valid;
    assign w_vec_cnt_next = r_vec_cnt + 16'd1;

    // Galois-style CRC-CCITT shift with the sampled response folded into bit 0.
    assign w_misr_next = {r_sig[SIG_W-2:0], 1'b0}
                       ^ (r_sig[SIG_W-1] ? MISR_POLY : '0)
                       ^ {{(SIG_W-1){1'b0}}, cone_out};

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state    <= ST_IDLE;
            r_cone_in  <= '0;
            r_sig      <= '0;
            r_ones     <= '0;
            r_vec_cnt  <= '0;
            r_num_vecs <= '0;
            r_settle   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_num_vecs <= num_vecs;
                        r_vec_cnt  <= '0;
                        r_sig      <= SIG_SEED;
                        r_ones     <= '0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        // An empty run goes straight to DONE; the DONE branch
                        // below raises done and drops busy one cycle later.
                        r_state    <= (num_vecs == 16'd0) ? ST_DONE : ST_LOAD;
                    end else if (r_state == ST_DONE) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (w_accept) begin
                        r_cone_in <= vec_data;
                        r_settle  <= '0;
                        r_state   <= ST_APPLY;
                    end
                end

                ST_APPLY: begin
                    r_settle <= r_settle + 4'd1;
                    if (r_settle == SETTLE_LAST) begin
                        r_state <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    r_sig     <= w_misr_next;
                    if (cone_out && (r_ones != ONES_MAX)) begin
                        r_ones <= r_ones + 1'b1;
                    end
                    r_vec_cnt <= w_vec_cnt_next;
                    if (w_vec_cnt_next == r_num_vecs) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign vec_ready  = w_vec_ready;
    assign cone_in    = r_cone_in;
    assign busy       = r_busy;
    assign done       = r_done;
    assign signature  = r_sig;
    assign ones_count = r_ones;
    assign dbg_state  = r_state;

endmodule

// File: doc/s9234_cone_eval_ctrl.md
Name: s9234_cone_eval_ctrl

Overview:
- Sequences evaluation of the combinationally-extracted s9234 partial-output cone (output n1146).
- Accepts 18-bit input vectors over a valid/ready stream and drives them onto the cone's pseudo-primary inputs.
- Waits a programmable settle time, samples n1146, and compacts the responses into a 16-bit MISR signature plus a ones count.
- Sits between the vector source (pattern ROM/TB driver) and the cone instance, and replaces the cut flip-flops for golden-signature checking.

Parameters:
- SETTLE_CYCLES, 2, cycles cone_in is held before n1146 is sampled; legal range 1..15.
- SIG_W, 16, signature and counter width; fixed at 16 in this revision.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RN  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- num_vecs  input  16  number of vectors in the run; latched on accepted start.
- vec_valid  input  1  vector source has data.
- vec_ready  output  1  controller can accept a vector.
- vec_data  input  18  vector bits [0..17] = g94,g102,g89,g98,g152,g107,g114,g123,g188,g157,g139,g128,g131,g135,g179,g161,g143,g170.
- cone_in  output  18  registered drive to the cone inputs, same bit order as vec_data.
- cone_out  input  1  n1146 from the cone.
- busy  output  1  high from the cycle after start is accepted until DONE is entered.
- done  output  1  level; high in DONE, cleared when the next start is accepted.
- signature  output  16  MISR state.
- ones_count  output  16  number of captures where cone_out was 1; saturates at 16'hFFFF.

Behaviour:
- Reset (RN low, asynchronous):
  - State goes to IDLE.
  - cone_in, signature, ones_count, internal vector counter and settle counter all go to 0.
  - busy, done and vec_ready go to 0.
  - Reset mid-run aborts the run with no partial result retained.
- States: IDLE, LOAD, APPLY, CAPTURE, DONE.
- IDLE/DONE, start=1:
  - Latch num_vecs; signature<=16'hFFFF; ones_count<=0; done<=0; busy<=1.
  - Go to DONE if num_vecs==0 (done=1 again next cycle, signature stays FFFF), else go to LOAD.
  - start is ignored in every other state.
- LOAD:
  - vec_ready=1 (combinational from state); it is 0 in every other state.
  - On vec_valid&vec_ready: cone_in<=vec_data, settle counter<=0, go to APPLY.
  - With no vec_valid, remain in LOAD indefinitely and hold cone_in.
- APPLY: increment the settle counter each cycle; when the counter reaches SETTLE_CYCLES-1, go to CAPTURE.
- CAPTURE (one cycle):
  - Sample cone_out.
  - signature <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {15'b0, cone_out}.
  - If cone_out=1 and ones_count≠FFFF, increment ones_count.
  - Increment the vector counter. If it equals the latched num_vecs, go to DONE (busy<=0, done<=1); else go to LOAD.
- Throughput with vec_valid held high: SETTLE_CYCLES+2 cycles per vector.
- cone_in holds the last vector through DONE and IDLE until the next accepted vector.
- num_vecs changes after start is accepted have no effect. Vector counter is 16 bits; num_vecs=16'hFFFF is legal.
- X on cone_out in CAPTURE is a bench error; RTL carries no special handling.

Test Plan:
- Reset mid-run: RN low during APPLY of vector 3 -> all outputs 0 in the same cycle, without waiting for CK. Then RN high, start with num_vecs=1 -> a fresh run with signature seeded FFFF.
- Zero-length run: start with num_vecs=0 -> vec_ready never asserts, done=1 two cycles after start, signature=16'hFFFF, ones_count=0.
- Single vector, real cone, vec_data=18'h0 (g89/g94/g98/g102=0 forces n1146=0), SETTLE_CYCLES=2 -> vec_ready accepted in cycle 1, CAPTURE in cycle 4, signature=16'hEFDF, ones_count=0, done=1.
- Single vector with cone_out stubbed to 1 -> signature=16'hEFDE, ones_count=1.
- Stalled stream: vec_valid low for 10 cycles in LOAD -> state holds, cone_in unchanged, busy=1. Then 4 back-to-back vectors -> exactly 4 captures at 4-cycle spacing, done after the 4th.
- Start ignored while busy: pulse start in APPLY with num_vecs=9 during a num_vecs=2 run -> run ends after 2 vectors. Then compare signature against a reference-model MISR over 256 random vectors through the real cone.
